// File: rtl/load_store_unit.sv
// Load/store unit: drives the synchronous data-memory port, buffers stores in a FIFO
// drained only in idle cycles, and forwards buffered data to loads on an address hit.
module load_store_unit #(
    parameter int SB_DEPTH = 4,
    parameter int AW       = 8,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid_ex,
    input  logic          req_rw_ex,
    input  logic [AW-1:0] addr_ex,
    input  logic [DW-1:0] wdata_ex,
    input  logic [4:0]    RW_ex,
    output logic          stall_lsu,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          ld_valid_dm,
    output logic [DW-1:0] ld_data_dm,
    output logic [4:0]    RW_ld_dm,
    output logic [2:0]    sb_count
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(SB_DEPTH);

    logic [AW-1:0] sb_addr_q [SB_DEPTH];
    logic [DW-1:0] sb_data_q [SB_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          ld_valid_q, ld_valid_d;
    logic          ld_miss_q, ld_miss_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic [4:0]    rw_ld_q, rw_ld_d;

    logic          is_load_s, is_store_s;
    logic          full_s, empty_s, stall_s;
    logic          hit_s;
    logic [DW-1:0] hit_data_s;
    logic          load_miss_s, push_s, pop_s;

    // Search valid entries oldest to youngest so the youngest match wins.
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            if ((CW'(k) < count_q) && (sb_addr_q[head_q + PW'(k)] == addr_ex)) begin
                hit_s      = 1'b1;
                hit_data_s = sb_data_q[head_q + PW'(k)];
            end else begin
                hit_s      = hit_s;
                hit_data_s = hit_data_s;
            end
        end
    end

    // Port arbitration: missing loads first, drains only in otherwise idle cycles.
    always_comb begin
        is_load_s   = req_valid_ex & ~req_rw_ex;
        is_store_s  = req_valid_ex & req_rw_ex;
        full_s      = (count_q == FULL_CNT);
        empty_s     = (count_q == '0);
        stall_s     = is_store_s & full_s;
        load_miss_s = is_load_s & ~hit_s;
        pop_s       = ~empty_s & (~req_valid_ex | (is_load_s & hit_s) | stall_s);
        push_s      = is_store_s & ~full_s;
    end

    assign stall_lsu = stall_s;
    assign mem_en    = reset & (load_miss_s | pop_s);
    assign mem_rw    = reset & pop_s;
    assign mem_addr  = load_miss_s ? addr_ex : sb_addr_q[head_q];
    assign mem_din   = sb_data_q[head_q];

    // Next-state for FIFO pointers, occupancy and the load-return stage.
    always_comb begin
        if (pop_s) begin
            head_d = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end

        if (push_s) begin
            tail_d = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end

        if (push_s) begin
            count_d = count_q + CW'(1);
        end else if (pop_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end

        ld_valid_d = is_load_s;
        ld_miss_d  = load_miss_s;

        if (is_load_s) begin
            rw_ld_d = RW_ex;
        end else begin
            rw_ld_d = rw_ld_q;
        end

        // A miss is captured as it returns so the result holds afterwards.
        if (is_load_s & hit_s) begin
            ld_data_d = hit_data_s;
        end else if (ld_valid_q & ld_miss_q) begin
            ld_data_d = mem_dout;
        end else begin
            ld_data_d = ld_data_q;
        end
    end

    // State registers; reset discards buffered stores and any pending load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ld_valid_q <= 1'b0;
            ld_miss_q  <= 1'b0;
            ld_data_q  <= '0;
            rw_ld_q    <= 5'd0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_q[i] <= '0;
                sb_data_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ld_valid_q <= ld_valid_d;
            ld_miss_q  <= ld_miss_d;
            ld_data_q  <= ld_data_d;
            rw_ld_q    <= rw_ld_d;
            if (push_s) begin
                sb_addr_q[tail_q] <= addr_ex;
                sb_data_q[tail_q] <= wdata_ex;
            end
        end
    end

    assign ld_valid_dm = ld_valid_q;
    assign ld_data_dm  = (ld_valid_q & ld_miss_q) ? mem_dout : ld_data_q;
    assign RW_ld_dm    = rw_ld_q;
    assign sb_count    = 3'(count_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic checked against an
// architectural model (program-order memory image and a queue of pending stores).
module tb_load_store_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid_ex, req_rw_ex;
    logic [7:0] addr_ex, wdata_ex;
    logic [4:0] RW_ex;
    logic       stall_lsu, mem_en, mem_rw;
    logic [7:0] mem_addr, mem_din, mem_dout;
    logic       ld_valid_dm;
    logic [7:0] ld_data_dm;
    logic [4:0] RW_ld_dm;
    logic [2:0] sb_count;

    logic [7:0] tbmem [256];
    logic [7:0] arch_mem [256];
    logic [7:0] dout_q;
    logic [7:0] sbq_a [$];
    logic [7:0] sbq_d [$];

    logic [21:0] obs_port, exp_port;
    logic [16:0] obs_res, exp_res;
    logic        last_stall;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.SB_DEPTH(4), .AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid_ex(req_valid_ex), .req_rw_ex(req_rw_ex),
        .addr_ex(addr_ex), .wdata_ex(wdata_ex), .RW_ex(RW_ex),
        .stall_lsu(stall_lsu), .mem_en(mem_en), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .ld_valid_dm(ld_valid_dm), .ld_data_dm(ld_data_dm),
        .RW_ld_dm(RW_ld_dm), .sb_count(sb_count)
    );

    assign mem_dout = dout_q;

    // Synchronous data memory seen by the DUT.
    initial begin
        for (int i = 0; i < 256; i++) tbmem[i] = 8'($urandom);
        tbmem[8'h10] = 8'h5A;
        dout_q <= 8'h00;
        forever begin
            @(posedge clk);
            if (mem_en === 1'b1) begin
                if (mem_rw === 1'b1) tbmem[mem_addr] = mem_din;
                else dout_q <= tbmem[mem_addr];
            end
        end
    end

    // One request cycle: capture port outputs before the edge, results after it,
    // and compute the expectations from the architectural model.
    task automatic drive_cycle(input logic v, input logic w, input logic [7:0] a,
                               input logic [7:0] d, input logic [4:0] r);
        logic is_ld, is_st, hit, full, e_stall, e_miss, e_drain, e_en;
        logic [7:0] e_ld;
        @(negedge clk);
        req_valid_ex = v; req_rw_ex = w; addr_ex = a; wdata_ex = d; RW_ex = r;
        #1;
        obs_port = {stall_lsu, mem_en, mem_rw, mem_en ? mem_addr : 8'h00,
                    mem_rw ? mem_din : 8'h00, sb_count};
        is_ld = v && !w;
        is_st = v && w;
        hit = 1'b0;
        foreach (sbq_a[i]) if (sbq_a[i] == a) hit = 1'b1;
        full    = (sbq_a.size() == DEPTH);
        e_stall = is_st && full;
        e_miss  = is_ld && !hit;
        e_drain = (sbq_a.size() != 0) && (!v || (is_ld && hit) || e_stall);
        e_en    = e_miss || e_drain;
        exp_port = {e_stall, e_en, e_drain,
                    e_miss ? a : (e_drain ? sbq_a[0] : 8'h00),
                    e_drain ? sbq_d[0] : 8'h00, 3'(sbq_a.size())};
        e_ld = arch_mem[a];
        last_stall = e_stall;
        @(posedge clk);
        if (e_drain) begin
            void'(sbq_a.pop_front());
            void'(sbq_d.pop_front());
        end
        if (is_st && !full) begin
            sbq_a.push_back(a);
            sbq_d.push_back(d);
            arch_mem[a] = d;
        end
        #1;
        obs_res = {ld_valid_dm, ld_valid_dm ? ld_data_dm : 8'h00,
                   ld_valid_dm ? RW_ld_dm : 5'h00, sb_count};
        exp_res = {is_ld, is_ld ? e_ld : 8'h00, is_ld ? r : 5'h00, 3'(sbq_a.size())};
    endtask

    task automatic sync_arch();
        for (int i = 0; i < 256; i++) arch_mem[i] = tbmem[i];
    endtask

    task automatic drain_all(input string tag);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
            checks++;
            if ({obs_port, obs_res} !== {exp_port, exp_res}) begin
                errors++;
                $display("FAIL %s_drain got %h/%h exp %h/%h", tag, obs_port, obs_res, exp_port, exp_res);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid_ex = 1'b1; req_rw_ex = 1'b0; addr_ex = 8'h10; wdata_ex = 8'h00; RW_ex = 5'd1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_en, mem_rw, stall_lsu, ld_valid_dm, ld_data_dm, RW_ld_dm, sb_count} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state got en%b rw%b st%b v%b d%h r%h c%0d exp all zero",
                     mem_en, mem_rw, stall_lsu, ld_valid_dm, ld_data_dm, RW_ld_dm, sb_count);
        end
        @(negedge clk);
        req_valid_ex = 1'b0;
        reset = 1'b1;
        sync_arch();
    endtask

    task automatic test_load_miss();
        drive_cycle(1'b1, 1'b0, 8'h10, 8'h00, 5'd7);
        checks++;
        if (obs_port !== {1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 3'd0}) begin
            errors++;
            $display("FAIL miss_port got %h exp %h", obs_port, {1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 3'd0});
        end
        checks++;
        if (obs_res !== {1'b1, 8'h5A, 5'd7, 3'd0}) begin
            errors++;
            $display("FAIL miss_result got %h exp %h", obs_res, {1'b1, 8'h5A, 5'd7, 3'd0});
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
        checks++;
        if ({ld_valid_dm, ld_data_dm} !== {1'b0, 8'h5A}) begin
            errors++;
            $display("FAIL hold_data got v%b d%h exp v0 d5a", ld_valid_dm, ld_data_dm);
        end
    endtask

    task automatic test_forward();
        drive_cycle(1'b1, 1'b1, 8'h20, 8'hAA, 5'd0);
        checks++;
        if ({obs_port, obs_res} !== {1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00, 5'd0, 3'd1}) begin
            errors++;
            $display("FAIL fwd_store got %h/%h exp port idle count 1", obs_port, obs_res);
        end
        drive_cycle(1'b1, 1'b0, 8'h20, 8'h00, 5'd3);
        checks++;
        if (obs_port !== {1'b0, 1'b1, 1'b1, 8'h20, 8'hAA, 3'd1}) begin
            errors++;
            $display("FAIL fwd_port got %h exp %h", obs_port, {1'b0, 1'b1, 1'b1, 8'h20, 8'hAA, 3'd1});
        end
        checks++;
        if (obs_res !== {1'b1, 8'hAA, 5'd3, 3'd0}) begin
            errors++;
            $display("FAIL fwd_result got %h exp %h", obs_res, {1'b1, 8'hAA, 5'd3, 3'd0});
        end
    endtask

    task automatic test_youngest();
        drive_cycle(1'b1, 1'b1, 8'h30, 8'h11, 5'd0);
        drive_cycle(1'b1, 1'b1, 8'h30, 8'h22, 5'd0);
        drive_cycle(1'b1, 1'b0, 8'h30, 8'h00, 5'd4);
        checks++;
        if (obs_port !== {1'b0, 1'b1, 1'b1, 8'h30, 8'h11, 3'd2}) begin
            errors++;
            $display("FAIL young_port got %h exp %h", obs_port, {1'b0, 1'b1, 1'b1, 8'h30, 8'h11, 3'd2});
        end
        checks++;
        if (obs_res !== {1'b1, 8'h22, 5'd4, 3'd1}) begin
            errors++;
            $display("FAIL young_result got %h exp %h", obs_res, {1'b1, 8'h22, 5'd4, 3'd1});
        end
        drain_all("young");
    endtask

    task automatic test_full_stall();
        logic [7:0] a, dd;
        for (int k = 0; k < 4; k++) begin
            a  = 8'h40 + 8'(k);
            dd = a ^ 8'hA5;
            drive_cycle(1'b1, 1'b1, a, dd, 5'd0);
            checks++;
            if ({obs_port, obs_res} !== {19'h0, 3'(k), 14'h0, 3'(k + 1)}) begin
                errors++;
                $display("FAIL fill_%0d got %h/%h exp count %0d", k, obs_port, obs_res, k + 1);
            end
        end
        drive_cycle(1'b1, 1'b1, 8'h44, 8'hE1, 5'd0);
        checks++;
        if ({obs_port, obs_res} !== {1'b1, 1'b1, 1'b1, 8'h40, 8'hE5, 3'd4, 14'h0, 3'd3}) begin
            errors++;
            $display("FAIL stall_cycle got %h/%h exp stall drain 40<-e5", obs_port, obs_res);
        end
        drive_cycle(1'b1, 1'b1, 8'h44, 8'hE1, 5'd0);
        checks++;
        if ({obs_port, obs_res} !== {19'h0, 3'd3, 14'h0, 3'd4}) begin
            errors++;
            $display("FAIL stall_retry got %h/%h exp accepted count 4", obs_port, obs_res);
        end
        drain_all("full");
    endtask

    task automatic test_drain_order();
        logic [7:0] ad [3];
        logic [7:0] dt [3];
        for (int i = 0; i < 3; i++) begin
            ad[i] = 8'h60 + 8'(i);
            dt[i] = 8'($urandom);
            drive_cycle(1'b1, 1'b1, ad[i], dt[i], 5'd0);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
            checks++;
            if (obs_port !== {1'b0, 1'b1, 1'b1, ad[i], dt[i], 3'(3 - i)}) begin
                errors++;
                $display("FAIL order_%0d got %h exp write %h<-%h", i, obs_port, ad[i], dt[i]);
            end
        end
        drive_cycle(1'b1, 1'b0, ad[1], 8'h00, 5'd12);
        checks++;
        if ({obs_port, obs_res} !== {1'b0, 1'b1, 1'b0, ad[1], 8'h00, 3'd0, 1'b1, dt[1], 5'd12, 3'd0}) begin
            errors++;
            $display("FAIL order_reload got %h/%h exp data %h", obs_port, obs_res, dt[1]);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 1'b1, 8'h70, 8'h01, 5'd0);
        drive_cycle(1'b1, 1'b1, 8'h71, 8'h02, 5'd0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 8'h78 + 8'(i), 8'h00, 5'(i + 20));
            checks++;
            if ({obs_port, obs_res} !== {exp_port, exp_res} || sb_count !== 3'd2) begin
                errors++;
                $display("FAIL b2b_%0d got %h/%h exp %h/%h", i, obs_port, obs_res, exp_port, exp_res);
            end
        end
        drain_all("b2b");
    endtask

    task automatic test_random();
        logic v, w;
        logic [7:0] a, d;
        logic [4:0] r;
        v = 1'b0; w = 1'b0; a = 8'h00; d = 8'h00; r = 5'd0;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                case ($urandom_range(0, 3))
                    0: begin v = 1'b0; w = 1'b0; end
                    1, 2: begin v = 1'b1; w = 1'b1; end
                    default: begin v = 1'b1; w = 1'b0; end
                endcase
                a = 8'h80 + 8'($urandom_range(0, 7));
                d = 8'($urandom);
                r = 5'($urandom);
            end
            drive_cycle(v, w, a, d, r);
            checks++;
            if ({obs_port, obs_res} !== {exp_port, exp_res}) begin
                errors++;
                $display("FAIL rand_%0d got %h/%h exp %h/%h", n, obs_port, obs_res, exp_port, exp_res);
            end
        end
        last_stall = 1'b0;
        drain_all("rand");
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 1'b1, 8'h50, 8'hC3, 5'd0);
        drive_cycle(1'b1, 1'b1, 8'h51, 8'h3C, 5'd0);
        drive_cycle(1'b1, 1'b0, 8'h58, 8'h00, 5'd9);
        @(negedge clk);
        req_valid_ex = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_rw, ld_valid_dm, sb_count} !== {1'b1, 1'b1, 1'b1, 3'd2}) begin
            errors++;
            $display("FAIL rstmid_pre got en%b rw%b v%b c%0d exp 1 1 1 2", mem_en, mem_rw, ld_valid_dm, sb_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_rw, ld_valid_dm, sb_count} !== 6'h0) begin
            errors++;
            $display("FAIL rstmid_clear got en%b rw%b v%b c%0d exp all zero", mem_en, mem_rw, ld_valid_dm, sb_count);
        end
        sbq_a.delete();
        sbq_d.delete();
        sync_arch();
        @(negedge clk);
        reset = 1'b1;
        drive_cycle(1'b1, 1'b0, 8'h50, 8'h00, 5'd2);
        checks++;
        if ({obs_port, obs_res} !== {1'b0, 1'b1, 1'b0, 8'h50, 8'h00, 3'd0, exp_res}) begin
            errors++;
            $display("FAIL rstmid_load got %h/%h exp read of 50 data %h", obs_port, obs_res, exp_res[15:8]);
        end
    endtask

    initial begin
        last_stall = 1'b0;
        test_reset();
        test_load_miss();
        test_forward();
        test_youngest();
        test_full_stall();
        test_drain_order();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
